// File: rtl/fpu_issue_sched_if.sv
// Decoder-to-scheduler request, unit fire pulses and FP writeback port of the FPU issue scheduler.
interface fpu_issue_sched_if;
  logic       io_req_valid;
  logic       io_req_ready;
  logic [4:0] io_req_tag;
  logic       io_sigs_wen;
  logic       io_sigs_fastpipe;
  logic       io_sigs_fma;
  logic       io_sigs_div;
  logic       io_sigs_sqrt;
  logic       io_sigs_fromint;
  logic       io_sigs_toint;
  logic       io_flush;
  logic       io_fast_fire;
  logic       io_fma_fire;
  logic       io_divsqrt_fire;
  logic       io_toint_fire;
  logic       io_divsqrt_busy;
  logic       io_wb_valid;
  logic [4:0] io_wb_tag;
  logic [1:0] io_wb_src;

  modport master (
    output io_req_valid, io_req_tag, io_sigs_wen, io_sigs_fastpipe, io_sigs_fma,
           io_sigs_div, io_sigs_sqrt, io_sigs_fromint, io_sigs_toint, io_flush,
    input  io_req_ready, io_fast_fire, io_fma_fire, io_divsqrt_fire, io_toint_fire,
           io_divsqrt_busy, io_wb_valid, io_wb_tag, io_wb_src
  );

  modport slave (
    input  io_req_valid, io_req_tag, io_sigs_wen, io_sigs_fastpipe, io_sigs_fma,
           io_sigs_div, io_sigs_sqrt, io_sigs_fromint, io_sigs_toint, io_flush,
    output io_req_ready, io_fast_fire, io_fma_fire, io_divsqrt_fire, io_toint_fire,
           io_divsqrt_busy, io_wb_valid, io_wb_tag, io_wb_src
  );
endinterface

// File: rtl/fpu_issue_sched.sv
// FPU issue scheduler: steers decoded ops to fast/FMA/divsqrt/toint units and
// reserves writeback slots so the FP register file sees at most one write per cycle.
//
// state | meaning
// IDLE  | div/sqrt unit free, divsqrt ops may issue
// RUN   | div/sqrt iterating, down-counter running
// PEND  | result ready but writeback slot taken; wen ops stalled
// WB    | div/sqrt result drives the writeback port this cycle
module fpu_issue_sched #(
  parameter int FAST_LAT   = 2,
  parameter int FMA_LAT    = 4,
  parameter int DIV_CYCLES = 20
) (
  input  logic             clock,
  input  logic             reset,
  fpu_issue_sched_if.slave io
);
  localparam int CW = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, PEND, WB} ds_state_e;

  ds_state_e     state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt, cnt_dec;
  logic [4:0]    ds_tag, ds_tag_nxt;
  logic          ds_wen, ds_wen_nxt;

  // Entry k holds the writeback landing k cycles from now.
  logic       tbl_v   [FMA_LAT];
  logic [4:0] tbl_tag [FMA_LAT];
  logic       tbl_fma [FMA_LAT];
  logic       nxt_v   [FMA_LAT];
  logic [4:0] nxt_tag [FMA_LAT];
  logic       nxt_fma [FMA_LAT];

  logic is_ds, is_fma, is_fast, is_toint, ready, accept;

  always_comb begin
    is_ds    = io.io_sigs_div | io.io_sigs_sqrt;
    is_fma   = !is_ds && io.io_sigs_fma;
    is_toint = !is_ds && !io.io_sigs_fma && !io.io_sigs_fastpipe && !io.io_sigs_fromint
               && io.io_sigs_toint;
    is_fast  = !is_ds && !is_fma && !is_toint;
  end

  // The FMA slot lies just past the table end, so it is always free after the shift.
  always_comb begin
    ready = 1'b1;
    if (io.io_flush)                          ready = 1'b0;
    else if (state == PEND && io.io_sigs_wen) ready = 1'b0;
    else if (is_ds)                           ready = (state == IDLE);
    else if (is_fast && io.io_sigs_wen)       ready = !tbl_v[FAST_LAT];
  end

  assign accept             = io.io_req_valid && ready;
  assign io.io_req_ready    = ready;
  assign io.io_fast_fire    = accept && is_fast;
  assign io.io_fma_fire     = accept && is_fma;
  assign io.io_divsqrt_fire = accept && is_ds;
  assign io.io_toint_fire   = accept && is_toint;

  always_comb begin
    for (int k = 0; k < FMA_LAT - 1; k++) begin
      nxt_v[k]   = tbl_v[k+1];
      nxt_tag[k] = tbl_tag[k+1];
      nxt_fma[k] = tbl_fma[k+1];
    end
    nxt_v[FMA_LAT-1]   = 1'b0;
    nxt_tag[FMA_LAT-1] = '0;
    nxt_fma[FMA_LAT-1] = 1'b0;
    if (accept && io.io_sigs_wen && is_fast) begin
      nxt_v[FAST_LAT-1]   = 1'b1;
      nxt_tag[FAST_LAT-1] = io.io_req_tag;
      nxt_fma[FAST_LAT-1] = 1'b0;
    end
    if (accept && io.io_sigs_wen && is_fma) begin
      nxt_v[FMA_LAT-1]   = 1'b1;
      nxt_tag[FMA_LAT-1] = io.io_req_tag;
      nxt_fma[FMA_LAT-1] = 1'b1;
    end
    if (io.io_flush) begin
      for (int k = 0; k < FMA_LAT; k++) begin
        nxt_v[k]   = 1'b0;
        nxt_tag[k] = '0;
        nxt_fma[k] = 1'b0;
      end
    end
  end

  // Terminal count is the decrement reaching zero, so the write lands DIV_CYCLES after accept.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    ds_tag_nxt = ds_tag;
    ds_wen_nxt = ds_wen;
    cnt_dec    = cnt - 1'b1;
    case (state)
      IDLE: if (accept && is_ds) begin
        state_nxt  = RUN;
        cnt_nxt    = CW'(DIV_CYCLES - 1);
        ds_tag_nxt = io.io_req_tag;
        ds_wen_nxt = io.io_sigs_wen;
      end
      RUN: begin
        cnt_nxt = cnt_dec;
        if (cnt_dec == '0) begin
          if (!ds_wen)        state_nxt = IDLE;
          else if (!nxt_v[0]) state_nxt = WB;
          else                state_nxt = PEND;
        end
      end
      PEND:    if (!nxt_v[0]) state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (io.io_flush) state_nxt = IDLE;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      ds_tag <= '0;
      ds_wen <= 1'b0;
      for (int k = 0; k < FMA_LAT; k++) begin
        tbl_v[k]   <= 1'b0;
        tbl_tag[k] <= '0;
        tbl_fma[k] <= 1'b0;
      end
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      ds_tag <= ds_tag_nxt;
      ds_wen <= ds_wen_nxt;
      for (int k = 0; k < FMA_LAT; k++) begin
        tbl_v[k]   <= nxt_v[k];
        tbl_tag[k] <= nxt_tag[k];
        tbl_fma[k] <= nxt_fma[k];
      end
    end
  end

  assign io.io_divsqrt_busy = (state != IDLE);
  assign io.io_wb_valid     = tbl_v[0] || (state == WB);
  assign io.io_wb_tag       = tbl_v[0] ? tbl_tag[0] : ((state == WB) ? ds_tag : 5'd0);
  assign io.io_wb_src       = tbl_v[0] ? {1'b0, tbl_fma[0]} : ((state == WB) ? 2'd2 : 2'd0);
endmodule

// File: tb/tb_fpu_issue_sched.sv
// Self-checking bench for fpu_issue_sched: directed scenarios plus randomized traffic
// compared against a cycle-indexed writeback calendar model.
module tb_fpu_issue_sched;
  localparam int FAST_LAT = 2, FMA_LAT = 4, DIV_CYCLES = 20;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  fpu_issue_sched_if io ();
  fpu_issue_sched #(.FAST_LAT(FAST_LAT), .FMA_LAT(FMA_LAT), .DIV_CYCLES(DIV_CYCLES))
    dut (.clock(clock), .reset(reset), .io(io));

  int checks = 0, errors = 0;

  typedef enum {C_FAST, C_FMA, C_DS, C_TOINT} cls_e;

  // Model: calendar of writes keyed by absolute cycle, plus one outstanding divsqrt.
  int         cyc;
  bit         r_v   [64];
  logic [4:0] r_tag [64];
  logic [1:0] r_src [64];
  bit         d_active, d_wen;
  int         d_acc, d_wbc;
  logic [4:0] d_tag;

  function automatic void model_reset();
    for (int i = 0; i < 64; i++) begin r_v[i] = 0; r_tag[i] = 0; r_src[i] = 0; end
    d_active = 0; d_wen = 0; d_acc = 0; d_wbc = -1; d_tag = 0; cyc = 0;
  endfunction

  function automatic void put(int c, logic [4:0] t, logic [1:0] s);
    r_v[c % 64] = 1; r_tag[c % 64] = t; r_src[c % 64] = s;
  endfunction

  function automatic cls_e op_class();
    if (io.io_sigs_div || io.io_sigs_sqrt) return C_DS;
    if (io.io_sigs_fma) return C_FMA;
    if (io.io_sigs_fastpipe || io.io_sigs_fromint) return C_FAST;
    if (io.io_sigs_toint) return C_TOINT;
    return C_FAST;
  endfunction

  function automatic bit m_busy();
    if (!d_active || cyc <= d_acc) return 0;
    if (d_wen) return (d_wbc < 0) || (cyc <= d_wbc);
    return cyc <= d_acc + DIV_CYCLES - 1;
  endfunction

  function automatic bit m_pend();
    return d_active && d_wen && d_wbc < 0 && cyc >= d_acc + DIV_CYCLES;
  endfunction

  function automatic bit m_ready();
    if (io.io_flush) return 0;
    if (io.io_sigs_wen && m_pend()) return 0;
    case (op_class())
      C_DS:    return !m_busy();
      C_FAST:  return io.io_sigs_wen ? !r_v[(cyc + FAST_LAT) % 64] : 1'b1;
      default: return 1;
    endcase
  endfunction

  function automatic void model_commit();
    bit   acc = io.io_req_valid && m_ready();
    cls_e c   = op_class();
    if (io.io_flush) begin
      for (int i = 0; i < 64; i++) r_v[i] = 0;
      d_active = 0;
    end else begin
      if (d_active && (d_wen ? (d_wbc >= 0 && cyc >= d_wbc) : (cyc >= d_acc + DIV_CYCLES - 1)))
        d_active = 0;
      if (acc && io.io_sigs_wen && c == C_FAST) put(cyc + FAST_LAT, io.io_req_tag, 2'd0);
      if (acc && io.io_sigs_wen && c == C_FMA)  put(cyc + FMA_LAT, io.io_req_tag, 2'd1);
      if (acc && c == C_DS) begin
        d_active = 1; d_acc = cyc; d_tag = io.io_req_tag; d_wen = io.io_sigs_wen; d_wbc = -1;
      end
      // Divsqrt takes the first free write cycle at or after its natural completion.
      if (d_active && d_wen && d_wbc < 0 && cyc + 1 >= d_acc + DIV_CYCLES && !r_v[(cyc + 1) % 64]) begin
        d_wbc = cyc + 1;
        put(cyc + 1, d_tag, 2'd2);
      end
    end
    r_v[cyc % 64] = 0;
    cyc++;
  endfunction

  task automatic drive(bit v, logic [4:0] tag, bit wen, bit fast, bit fma, bit dv, bit sq,
                       bit fi, bit ti, bit fl);
    io.io_req_valid = v; io.io_req_tag = tag; io.io_sigs_wen = wen;
    io.io_sigs_fastpipe = fast; io.io_sigs_fma = fma; io.io_sigs_div = dv; io.io_sigs_sqrt = sq;
    io.io_sigs_fromint = fi; io.io_sigs_toint = ti; io.io_flush = fl;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    model_commit();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle();
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle();
    #2;
    checks++;
    if (io.io_req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready got=%b exp=1", io.io_req_ready);
    end
    checks++;
    if ({io.io_fast_fire, io.io_fma_fire, io.io_divsqrt_fire, io.io_toint_fire, io.io_divsqrt_busy,
         io.io_wb_valid, io.io_wb_tag, io.io_wb_src} !== 13'd0) begin
      errors++; $display("FAIL reset_outputs got=%b exp=0", {io.io_fast_fire, io.io_fma_fire,
        io.io_divsqrt_fire, io.io_toint_fire, io.io_divsqrt_busy, io.io_wb_valid, io.io_wb_tag, io.io_wb_src});
    end
    do_reset();
  endtask

  task automatic test_fast_single();
    do_reset();
    for (int k = 0; k < 15; k++) begin
      if (k == 10) drive(1, 3, 1, 1, 0, 0, 0, 0, 0, 0); else idle();
      #4;
      checks++;
      if (io.io_fast_fire !== (k == 10)) begin
        errors++; $display("FAIL fast_fire k=%0d got=%b exp=%b", k, io.io_fast_fire, k == 10);
      end
      checks++;
      if (io.io_wb_valid !== (k == 12)) begin
        errors++; $display("FAIL fast_wb_valid k=%0d got=%b exp=%b", k, io.io_wb_valid, k == 12);
      end
      if (k == 12) begin
        checks++;
        if ({io.io_wb_tag, io.io_wb_src} !== {5'd3, 2'd0}) begin
          errors++; $display("FAIL fast_wb_data got=%0d/%0d exp=3/0", io.io_wb_tag, io.io_wb_src);
        end
      end
      tick();
    end
  endtask

  task automatic test_fma_fast_collision();
    bit exp_v; logic [6:0] exp_d;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      if (k == 0) drive(1, 5, 1, 0, 1, 0, 0, 0, 0, 0);
      else if (k == 2 || k == 3) drive(1, 6, 1, 1, 0, 0, 0, 0, 0, 0);
      else idle();
      #4;
      if (k == 2 || k == 3) begin
        checks++;
        if (io.io_req_ready !== (k == 3)) begin
          errors++; $display("FAIL coll_ready k=%0d got=%b exp=%b", k, io.io_req_ready, k == 3);
        end
      end
      exp_v = (k == 4 || k == 5);
      exp_d = (k == 4) ? {5'd5, 2'd1} : {5'd6, 2'd0};
      checks++;
      if (io.io_wb_valid !== exp_v || (exp_v && {io.io_wb_tag, io.io_wb_src} !== exp_d)) begin
        errors++; $display("FAIL coll_wb k=%0d got=%b/%0d/%0d exp=%b/%0d/%0d", k, io.io_wb_valid,
                           io.io_wb_tag, io.io_wb_src, exp_v, exp_d[6:2], exp_d[1:0]);
      end
      tick();
    end
  endtask

  task automatic test_div_pend();
    bit exp_v; logic [6:0] exp_d;
    do_reset();
    for (int k = 0; k < 25; k++) begin
      if (k == 0) drive(1, 7, 1, 0, 0, 1, 0, 0, 0, 0);
      else if (k == 16) drive(1, 8, 1, 0, 1, 0, 0, 0, 0, 0);
      else if (k == 20 || k == 21) drive(1, 9, 1, 1, 0, 0, 0, 0, 0, 0);
      else idle();
      #4;
      if (k == 20 || k == 21) begin
        checks++;
        if (io.io_req_ready !== (k == 21)) begin
          errors++; $display("FAIL pend_ready k=%0d got=%b exp=%b", k, io.io_req_ready, k == 21);
        end
      end
      checks++;
      if (io.io_divsqrt_busy !== (k >= 1 && k <= 21)) begin
        errors++; $display("FAIL pend_busy k=%0d got=%b exp=%b", k, io.io_divsqrt_busy, k >= 1 && k <= 21);
      end
      exp_v = (k == 20 || k == 21 || k == 23);
      exp_d = (k == 20) ? {5'd8, 2'd1} : (k == 21) ? {5'd7, 2'd2} : {5'd9, 2'd0};
      checks++;
      if (io.io_wb_valid !== exp_v || (exp_v && {io.io_wb_tag, io.io_wb_src} !== exp_d)) begin
        errors++; $display("FAIL pend_wb k=%0d got=%b/%0d/%0d exp=%b/%0d/%0d", k, io.io_wb_valid,
                           io.io_wb_tag, io.io_wb_src, exp_v, exp_d[6:2], exp_d[1:0]);
      end
      tick();
    end
  endtask

  task automatic test_div_busy_toint();
    bit exp_r, exp_v; logic [6:0] exp_d;
    do_reset();
    for (int k = 0; k < 46; k++) begin
      if (k == 0) drive(1, 1, 1, 0, 0, 1, 0, 0, 0, 0);
      else if (k == 5) drive(1, 4, 0, 0, 0, 0, 0, 0, 1, 0);
      else if (k <= 21) drive(1, 2, 1, 0, 0, 0, 1, 0, 0, 0);
      else idle();
      #4;
      if (k <= 21) begin
        exp_r = (k == 0 || k == 5 || k == 21);
        checks++;
        if (io.io_req_ready !== exp_r) begin
          errors++; $display("FAIL busy_ready k=%0d got=%b exp=%b", k, io.io_req_ready, exp_r);
        end
      end
      checks++;
      if ({io.io_divsqrt_fire, io.io_toint_fire} !== {(k == 0 || k == 21), (k == 5)}) begin
        errors++; $display("FAIL busy_fire k=%0d got=%b%b exp=%b%b", k, io.io_divsqrt_fire,
                           io.io_toint_fire, (k == 0 || k == 21), (k == 5));
      end
      exp_v = (k == 20 || k == 41);
      exp_d = (k == 20) ? {5'd1, 2'd2} : {5'd2, 2'd2};
      checks++;
      if (io.io_wb_valid !== exp_v || (exp_v && {io.io_wb_tag, io.io_wb_src} !== exp_d)) begin
        errors++; $display("FAIL busy_wb k=%0d got=%b/%0d/%0d exp=%b/%0d/%0d", k, io.io_wb_valid,
                           io.io_wb_tag, io.io_wb_src, exp_v, exp_d[6:2], exp_d[1:0]);
      end
      tick();
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int k = 0; k < 30; k++) begin
      if (k == 0) drive(1, 10, 1, 0, 0, 1, 0, 0, 0, 0);
      else if (k == 1) drive(1, 11, 1, 0, 1, 0, 0, 0, 0, 0);
      else if (k == 2) drive(1, 12, 1, 1, 0, 0, 0, 0, 0, 1);
      else idle();
      #4;
      if (k == 2) begin
        checks++;
        if ({io.io_req_ready, io.io_fast_fire} !== 2'b00) begin
          errors++; $display("FAIL flush_ready got=%b%b exp=00", io.io_req_ready, io.io_fast_fire);
        end
      end
      checks++;
      if (io.io_divsqrt_busy !== (k == 1 || k == 2)) begin
        errors++; $display("FAIL flush_busy k=%0d got=%b exp=%b", k, io.io_divsqrt_busy, k == 1 || k == 2);
      end
      checks++;
      if (io.io_wb_valid !== 1'b0) begin
        errors++; $display("FAIL flush_wb k=%0d got=%b exp=0", k, io.io_wb_valid);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_div();
    do_reset();
    for (int k = 0; k < 6; k++) begin
      if (k == 0) drive(1, 12, 1, 0, 0, 1, 0, 0, 0, 0); else idle();
      #4;
      if (k == 5) begin
        checks++;
        if (io.io_divsqrt_busy !== 1'b1) begin
          errors++; $display("FAIL rstdiv_busy_before got=%b exp=1", io.io_divsqrt_busy);
        end
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if ({io.io_divsqrt_busy, io.io_wb_valid} !== 2'b00) begin
          errors++; $display("FAIL rstdiv_async got=%b%b exp=00", io.io_divsqrt_busy, io.io_wb_valid);
        end
      end else tick();
    end
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b1;
    for (int k = 0; k < 23; k++) begin
      if (k == 0) drive(1, 13, 1, 0, 0, 1, 0, 0, 0, 0); else idle();
      #4;
      if (k == 0) begin
        checks++;
        if ({io.io_req_ready, io.io_divsqrt_fire} !== 2'b11) begin
          errors++; $display("FAIL rstdiv_accept got=%b%b exp=11", io.io_req_ready, io.io_divsqrt_fire);
        end
      end
      checks++;
      if (io.io_wb_valid !== (k == 20) || (k == 20 && {io.io_wb_tag, io.io_wb_src} !== {5'd13, 2'd2})) begin
        errors++; $display("FAIL rstdiv_wb k=%0d got=%b/%0d/%0d exp=%b/13/2", k, io.io_wb_valid,
                           io.io_wb_tag, io.io_wb_src, k == 20);
      end
      tick();
    end
  endtask

  task automatic test_random();
    bit er; cls_e c; logic [3:0] ef;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 99) < 75, 5'($urandom_range(0, 31)), $urandom_range(0, 99) < 85,
            $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 35, $urandom_range(0, 99) < 4,
            $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 20,
            $urandom_range(0, 199) < 2);
      #4;
      er = m_ready();
      c  = op_class();
      ef = {io.io_req_valid && er && c == C_FAST, io.io_req_valid && er && c == C_FMA,
            io.io_req_valid && er && c == C_DS, io.io_req_valid && er && c == C_TOINT};
      checks++;
      if (io.io_req_ready !== er) begin
        errors++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, io.io_req_ready, er);
      end
      checks++;
      if ({io.io_fast_fire, io.io_fma_fire, io.io_divsqrt_fire, io.io_toint_fire} !== ef) begin
        errors++; $display("FAIL rnd_fire cyc=%0d got=%b exp=%b", cyc,
          {io.io_fast_fire, io.io_fma_fire, io.io_divsqrt_fire, io.io_toint_fire}, ef);
      end
      checks++;
      if (io.io_divsqrt_busy !== m_busy()) begin
        errors++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", cyc, io.io_divsqrt_busy, m_busy());
      end
      checks++;
      if (io.io_wb_valid !== r_v[cyc % 64]) begin
        errors++; $display("FAIL rnd_wb_valid cyc=%0d got=%b exp=%b", cyc, io.io_wb_valid, r_v[cyc % 64]);
      end
      if (r_v[cyc % 64]) begin
        checks++;
        if ({io.io_wb_tag, io.io_wb_src} !== {r_tag[cyc % 64], r_src[cyc % 64]}) begin
          errors++; $display("FAIL rnd_wb_data cyc=%0d got=%0d/%0d exp=%0d/%0d", cyc, io.io_wb_tag,
                             io.io_wb_src, r_tag[cyc % 64], r_src[cyc % 64]);
        end
      end
      tick();
    end
  endtask

  initial begin
    idle();
    model_reset();
    test_reset();
    test_fast_single();
    test_fma_fast_collision();
    test_div_pend();
    test_div_busy_toint();
    test_flush();
    test_reset_mid_div();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
